// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the lane-parallel signed matrix multiplier.
package matrix_mult_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StMac,
    StDrain,
    StDone
  } state_e;

  localparam logic SAT_WRAP  = 1'b0;
  localparam logic SAT_CLAMP = 1'b1;

  // Width of the intermediate used by convert(); accumulators and results must fit below it.
  localparam int unsigned CONV_W = 64;

  typedef struct packed {
    logic                     ovf;
    logic signed [CONV_W-1:0] value;
  } conv_t;

  // Wide enough that an N-term sum of full-scale products can never overflow.
  function automatic int unsigned acc_width(input int unsigned data_width, input int unsigned n);
    return 2 * data_width + $clog2(n) + 1;
  endfunction

  // Reduce a sign-extended accumulator to out_width bits, by wrapping or clamping.
  function automatic conv_t convert(input logic signed [CONV_W-1:0] acc,
                                    input int unsigned              out_width,
                                    input logic                     mode);
    conv_t                    res;
    logic signed [CONV_W-1:0] hi;
    logic signed [CONV_W-1:0] lo;
    logic signed [CONV_W-1:0] shifted;
    logic signed [CONV_W-1:0] wrapped;
    hi      = '0;
    hi[0]   = 1'b1;
    hi      = (hi << (out_width - 1)) - 64'sd1;
    lo      = ~hi;
    shifted = acc <<< (CONV_W - out_width);
    wrapped = shifted >>> (CONV_W - out_width);
    if (mode == SAT_CLAMP) begin
      if (acc > hi) begin
        res.value = hi;
      end else if (acc < lo) begin
        res.value = lo;
      end else begin
        res.value = acc;
      end
    end else begin
      res.value = wrapped;
    end
    res.ovf = (res.value != acc);
    return res;
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One signed multiply-accumulate lane; result presents the sum including the current product.
module mac_lane #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ACC_WIDTH  = 19
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  result
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [ACC_WIDTH-1:0]    prod_ext;
  logic signed [ACC_WIDTH-1:0]    acc_q;
  logic signed [ACC_WIDTH-1:0]    acc_d;

  assign prod     = a * b;
  assign prod_ext = {{(ACC_WIDTH - 2 * DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
  assign result   = acc_q + prod_ext;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = result;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mult_lanes.sv
// Signed C = A x B with LANES output columns accumulated in parallel and a
// valid/ready result stream; A/B are loaded through word-addressed write ports while idle.
module matrix_mult_lanes
  import matrix_mult_pkg::*;
#(
  parameter int unsigned M          = 4,
  parameter int unsigned N          = 4,
  parameter int unsigned P          = 4,
  parameter int unsigned LANES      = 2,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned OUT_WIDTH  = 2 * DATA_WIDTH,
  localparam int unsigned AAW = (M * N > 1) ? $clog2(M * N) : 1,
  localparam int unsigned BAW = (N * P > 1) ? $clog2(N * P) : 1,
  localparam int unsigned RW  = (M > 1) ? $clog2(M) : 1,
  localparam int unsigned CW  = (P > 1) ? $clog2(P) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic                        sat_mode,
  input  logic [DATA_WIDTH-1:0]       a_in,
  input  logic [AAW-1:0]              a_addr,
  input  logic                        a_wen,
  input  logic [DATA_WIDTH-1:0]       b_in,
  input  logic [BAW-1:0]              b_addr,
  input  logic                        b_wen,
  output logic signed [OUT_WIDTH-1:0] c_out,
  output logic [RW-1:0]               c_row,
  output logic [CW-1:0]               c_col,
  output logic                        c_valid,
  input  logic                        c_ready,
  output logic                        done,
  output logic                        ovf,
  output logic                        wr_err
);

  localparam int unsigned ACC_W = acc_width(DATA_WIDTH, N);
  localparam int unsigned KW    = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  if (P % LANES != 0) begin : g_bad_lanes
    $error("P must be a multiple of LANES");
  end
  if (ACC_W >= CONV_W || OUT_WIDTH >= CONV_W) begin : g_bad_width
    $error("accumulator and output widths must stay below CONV_W");
  end

  state_e                             state_q, state_d;
  logic [RW-1:0]                      row_q, row_d;
  logic [CW-1:0]                      col_base_q, col_base_d;
  logic [KW-1:0]                      k_q, k_d;
  logic [LW-1:0]                      lane_q, lane_d;
  logic                               sat_q, sat_d;
  logic                               ovf_q, ovf_d;
  logic                               wr_err_q, wr_err_d;
  logic [LANES-1:0][OUT_WIDTH-1:0]    hold_q, hold_d;
  logic [LANES-1:0][OUT_WIDTH-1:0]    lane_val;
  logic [LANES-1:0]                   lane_ovf;

  logic [DATA_WIDTH-1:0] a_mem [M*N];
  logic [DATA_WIDTH-1:0] b_mem [N*P];
  logic [AAW-1:0]        a_idx;
  logic                  mac_en;

  // Operand memories carry no reset so a restart after rst_n reuses the loaded data.
  always_ff @(posedge clk) begin
    if (state_q == StIdle && a_wen && 32'(a_addr) < M * N) begin
      a_mem[a_addr] <= a_in;
    end
    if (state_q == StIdle && b_wen && 32'(b_addr) < N * P) begin
      b_mem[b_addr] <= b_in;
    end
  end

  assign a_idx  = AAW'(32'(row_q) * N + 32'(k_q));
  assign mac_en = (state_q == StMac);

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [BAW-1:0]           b_idx;
    logic signed [ACC_W-1:0]  sum;
    conv_t                    conv;
    logic                     unused_conv_hi;

    assign b_idx = BAW'(32'(k_q) * P + 32'(col_base_q) + l);

    mac_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_W)
    ) u_mac_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (!mac_en),
      .en    (mac_en),
      .a     (a_mem[a_idx]),
      .b     (b_mem[b_idx]),
      .result(sum)
    );

    assign conv           = convert({{(CONV_W - ACC_W){sum[ACC_W-1]}}, sum}, OUT_WIDTH, sat_q);
    assign lane_val[l]    = conv.value[OUT_WIDTH-1:0];
    assign lane_ovf[l]    = conv.ovf;
    assign unused_conv_hi = ^conv.value[CONV_W-1:OUT_WIDTH];
  end

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    col_base_d = col_base_q;
    k_d        = k_q;
    lane_d     = lane_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    wr_err_d   = wr_err_q;
    hold_d     = hold_q;

    if (state_q != StIdle && (a_wen || b_wen)) begin
      wr_err_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StMac;
          row_d      = '0;
          col_base_d = '0;
          k_d        = '0;
          lane_d     = '0;
          sat_d      = sat_mode;
          ovf_d      = 1'b0;
          wr_err_d   = 1'b0;
        end
      end
      StMac: begin
        if (k_q == KW'(N - 1)) begin
          // Lane sums already include the final product, so capture them this cycle.
          k_d     = '0;
          state_d = StDrain;
          hold_d  = lane_val;
          if (|lane_ovf) begin
            ovf_d = 1'b1;
          end
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      StDrain: begin
        if (c_ready) begin
          if (lane_q == LW'(LANES - 1)) begin
            lane_d = '0;
            if (32'(col_base_q) + LANES < P) begin
              col_base_d = col_base_q + CW'(LANES);
              state_d    = StMac;
            end else if (32'(row_q) < M - 1) begin
              row_d      = row_q + RW'(1);
              col_base_d = '0;
              state_d    = StMac;
            end else begin
              state_d = StDone;
            end
          end else begin
            lane_d = lane_q + LW'(1);
          end
        end
      end
      StDone: begin
        if (!start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      row_q      <= '0;
      col_base_q <= '0;
      k_q        <= '0;
      lane_q     <= '0;
      sat_q      <= SAT_WRAP;
      ovf_q      <= 1'b0;
      wr_err_q   <= 1'b0;
      hold_q     <= '0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      col_base_q <= col_base_d;
      k_q        <= k_d;
      lane_q     <= lane_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      wr_err_q   <= wr_err_d;
      hold_q     <= hold_d;
    end
  end

  assign c_out   = hold_q[lane_q];
  assign c_row   = row_q;
  assign c_col   = col_base_q + CW'(lane_q);
  assign c_valid = (state_q == StDrain);
  assign done    = (state_q == StDone);
  assign ovf     = ovf_q;
  assign wr_err  = wr_err_q;

endmodule
